// File: rtl/lb2ocu_scan_sequencer_pkg.sv
// Shared types for the conv-layer scan sequencer.
//   padding_type : SAME / VALID layer padding mode
//   seq_state_e  : scan sequencer FSM states
package lb2ocu_scan_sequencer_pkg;

  typedef enum logic {
    PAD_SAME  = 1'b0,
    PAD_VALID = 1'b1
  } padding_type;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_WAIT_ROW,
    SEQ_ISSUE,
    SEQ_DONE
  } seq_state_e;

endpackage

// File: rtl/lb2ocu_scan_sequencer_stride_counter.sv
// One axis of the window-centre raster: walks start..end in steps of step.
//   load_i    : capture start/end/step and jump to start (new layer)
//   rewind_i  : jump back to the captured start (column at end of row)
//   advance_i : cnt += step
//   addr_o    : current position, registered
//   wrap_o    : lookahead, the next advance would pass end (registers only)
// Position/bounds carry one extra MSB so end = W-1 never wraps and
// cnt + step is compared without overflow.
module stride_counter #(
  parameter int AW = 5,
  parameter int SW = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [AW:0]   start_i,
  input  logic [AW:0]   end_i,
  input  logic [SW-1:0] step_i,
  input  logic          rewind_i,
  input  logic          advance_i,
  output logic [AW-1:0] addr_o,
  output logic          wrap_o
);
  localparam int NW = AW + 2;

  logic [AW:0]   start_q, end_q, cnt_q;
  logic [SW-1:0] step_q;
  logic [NW-1:0] cnt_nxt;

  assign cnt_nxt = {1'b0, cnt_q} + NW'(step_q);
  assign wrap_o  = cnt_nxt > {1'b0, end_q};
  assign addr_o  = cnt_q[AW-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_q <= '0;
      end_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      start_q <= start_i;
      end_q   <= end_i;
      step_q  <= step_i;
      cnt_q   <= start_i;
    end else if (rewind_i) begin
      cnt_q   <= start_q;
    end else if (advance_i) begin
      cnt_q   <= cnt_nxt[AW:0];
    end
  end

endmodule

// File: rtl/lb2ocu_scan_sequencer.sv
// Raster sequencer of output-window centres for the linebuffer->OCU read path.
//   clk_i, rst_ni            : clock, async active-low reset
//   new_layer_i              : latch layer_* config and (re)start the scan
//   layer_stride_*_i         : strides (0 behaves as 1)
//   layer_padding_type_i     : SAME / VALID
//   layer_imagewidth/height_i: image size W / H
//   lb_rows_written_i        : image rows present in the linebuffer
//   ready_i / valid_o        : window handshake, read_col_o / read_row_o address
//   last_o                   : presented window is the final one of the layer
//   busy_o, layer_done_o     : scan active, 1-cycle completion pulse
module lb2ocu_scan_sequencer
  import lb2ocu_scan_sequencer_pkg::*;
#(
  parameter int K               = 3,
  parameter int IMAGEWIDTH      = 32,
  parameter int IMAGEHEIGHT     = 32,
  parameter int COLADDRESSWIDTH = $clog2(IMAGEWIDTH),
  parameter int ROWADDRESSWIDTH = $clog2(IMAGEHEIGHT)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       new_layer_i,
  input  logic [$clog2(K)-1:0]       layer_stride_width_i,
  input  logic [$clog2(K)-1:0]       layer_stride_height_i,
  input  padding_type                layer_padding_type_i,
  input  logic [COLADDRESSWIDTH:0]   layer_imagewidth_i,
  input  logic [ROWADDRESSWIDTH:0]   layer_imageheight_i,
  input  logic [ROWADDRESSWIDTH:0]   lb_rows_written_i,
  input  logic                       ready_i,
  output logic                       valid_o,
  output logic [COLADDRESSWIDTH-1:0] read_col_o,
  output logic [ROWADDRESSWIDTH-1:0] read_row_o,
  output logic                       last_o,
  output logic                       busy_o,
  output logic                       layer_done_o
);
  localparam int HK  = (K - 1) / 2;
  localparam int SW  = $clog2(K);
  localparam int CAW = COLADDRESSWIDTH + 1;
  localparam int RAW = ROWADDRESSWIDTH + 1;
  localparam int RNW = ROWADDRESSWIDTH + 2;

  typedef struct packed {
    padding_type    pad;
    logic [RAW-1:0] height;
  } layer_cfg_t;

  layer_cfg_t cfg_q;
  seq_state_e state_q, state_d;

  logic           valid_pad, empty_layer;
  logic [SW-1:0]  step_w, step_h;
  logic [CAW-1:0] col_start, col_end;
  logic [RAW-1:0] row_start, row_end;
  logic [RNW-1:0] fill_need;
  logic           fill_ok;
  logic           col_wrap, row_wrap, col_adv, col_rewind, row_adv;

  // Window bounds from the incoming config; only consumed on new_layer_i.
  // A layer with no window (VALID smaller than the kernel, or a zero-sized
  // image) goes straight to DONE so the consumer still sees completion.
  always_comb begin
    valid_pad = (layer_padding_type_i == PAD_VALID);
    step_w    = (layer_stride_width_i  == '0) ? SW'(1) : layer_stride_width_i;
    step_h    = (layer_stride_height_i == '0) ? SW'(1) : layer_stride_height_i;
    col_start = valid_pad ? CAW'(HK) : '0;
    row_start = valid_pad ? RAW'(HK) : '0;
    col_end   = layer_imagewidth_i  - CAW'(1) - col_start;
    row_end   = layer_imageheight_i - RAW'(1) - row_start;
    if (valid_pad)
      empty_layer = (layer_imagewidth_i < CAW'(K)) || (layer_imageheight_i < RAW'(K));
    else
      empty_layer = (layer_imagewidth_i == '0) || (layer_imageheight_i == '0);
  end

  // Row r needs its bottom kernel row, clipped at the last image row.
  always_comb begin
    fill_need = {2'b00, read_row_o} + RNW'(HK + 1);
    if (fill_need > {1'b0, cfg_q.height})
      fill_need = {1'b0, cfg_q.height};
  end
  assign fill_ok = {1'b0, lb_rows_written_i} >= fill_need;

  stride_counter #(.AW(COLADDRESSWIDTH), .SW(SW)) u_col (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (new_layer_i),
    .start_i   (col_start),
    .end_i     (col_end),
    .step_i    (step_w),
    .rewind_i  (col_rewind),
    .advance_i (col_adv),
    .addr_o    (read_col_o),
    .wrap_o    (col_wrap)
  );

  stride_counter #(.AW(ROWADDRESSWIDTH), .SW(SW)) u_row (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (new_layer_i),
    .start_i   (row_start),
    .end_i     (row_end),
    .step_i    (step_h),
    .rewind_i  (1'b0),
    .advance_i (row_adv),
    .addr_o    (read_row_o),
    .wrap_o    (row_wrap)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEQ_IDLE;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      if (new_layer_i) begin
        cfg_q.pad    <= layer_padding_type_i;
        cfg_q.height <= layer_imageheight_i;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    col_adv    = 1'b0;
    col_rewind = 1'b0;
    row_adv    = 1'b0;
    case (state_q)
      SEQ_IDLE:     ;
      SEQ_WAIT_ROW: if (fill_ok) state_d = SEQ_ISSUE;
      SEQ_ISSUE: begin
        if (ready_i) begin
          if (!col_wrap) begin
            col_adv = 1'b1;
          end else begin
            col_rewind = 1'b1;
            if (row_wrap) begin
              state_d = SEQ_DONE;
            end else begin
              row_adv = 1'b1;
              state_d = SEQ_WAIT_ROW;
            end
          end
        end
      end
      SEQ_DONE:     state_d = SEQ_IDLE;
      default:      state_d = SEQ_IDLE;
    endcase
    // A new layer overrides everything; counters reload on the same edge.
    // From DONE this still lets the current done pulse go out.
    if (new_layer_i)
      state_d = empty_layer ? SEQ_DONE : SEQ_WAIT_ROW;
  end

  assign valid_o      = (state_q == SEQ_ISSUE);
  assign busy_o       = (state_q != SEQ_IDLE);
  assign layer_done_o = (state_q == SEQ_DONE);
  assign last_o       = valid_o & col_wrap & row_wrap;

endmodule

// File: tb/tb_lb2ocu_scan_sequencer.sv
module tb_lb2ocu_scan_sequencer;
  import lb2ocu_scan_sequencer_pkg::*;

  localparam int K  = 3;
  localparam int CW = 5;
  localparam int RW = 5;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          new_layer_i = 1'b0;
  logic [1:0]    layer_stride_width_i = '0;
  logic [1:0]    layer_stride_height_i = '0;
  padding_type   layer_padding_type_i = PAD_SAME;
  logic [CW:0]   layer_imagewidth_i = '0;
  logic [RW:0]   layer_imageheight_i = '0;
  logic [RW:0]   lb_rows_written_i = '0;
  logic          ready_i = 1'b0;
  logic          valid_o, last_o, busy_o, layer_done_o;
  logic [CW-1:0] read_col_o;
  logic [RW-1:0] read_row_o;

  lb2ocu_scan_sequencer #(.K(K), .IMAGEWIDTH(32), .IMAGEHEIGHT(32)) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .new_layer_i           (new_layer_i),
    .layer_stride_width_i  (layer_stride_width_i),
    .layer_stride_height_i (layer_stride_height_i),
    .layer_padding_type_i  (layer_padding_type_i),
    .layer_imagewidth_i    (layer_imagewidth_i),
    .layer_imageheight_i   (layer_imageheight_i),
    .lb_rows_written_i     (lb_rows_written_i),
    .ready_i               (ready_i),
    .valid_o               (valid_o),
    .read_col_o            (read_col_o),
    .read_row_o            (read_row_o),
    .last_o                (last_o),
    .busy_o                (busy_o),
    .layer_done_o          (layer_done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int c; int r; } win_t;
  win_t exp_q[$];
  int   m_h;
  int   stall_r = -1, stall_c = -1, stall_left = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: enumerate every window centre of the layer in raster order.
  task automatic build_model(input padding_type pad, input int w, input int h,
                             input int sw, input int sh);
    int   swe, she, lo;
    bit   empty;
    win_t wv;
    swe = (sw == 0) ? 1 : sw;
    she = (sh == 0) ? 1 : sh;
    lo  = (pad == PAD_VALID) ? (K - 1) / 2 : 0;
    empty = (pad == PAD_VALID) ? (w < K || h < K) : (w == 0 || h == 0);
    exp_q.delete();
    m_h = h;
    if (!empty)
      for (int r = lo; r <= h - 1 - lo; r += she)
        for (int c = lo; c <= w - 1 - lo; c += swe) begin
          wv.c = c;
          wv.r = r;
          exp_q.push_back(wv);
        end
  endtask

  task automatic drive_cfg(input padding_type pad, input int w, input int h,
                           input int sw, input int sh);
    layer_padding_type_i  = pad;
    layer_imagewidth_i    = (CW+1)'(w);
    layer_imageheight_i   = (RW+1)'(h);
    layer_stride_width_i  = 2'(sw);
    layer_stride_height_i = 2'(sh);
  endtask

  // Pulse new_layer_i in cycle 0, then scramble the config ports (must be
  // ignored). Returns at the drive point of cycle 1.
  task automatic start_layer(input padding_type pad, input int w, input int h,
                             input int sw, input int sh);
    build_model(pad, w, h, sw, sh);
    drive_cfg(pad, w, h, sw, sh);
    new_layer_i = 1'b1;
    @(posedge clk_i); #1;
    new_layer_i = 1'b0;
    layer_padding_type_i  = padding_type'($urandom_range(1));
    layer_imagewidth_i    = (CW+1)'($urandom);
    layer_imageheight_i   = (RW+1)'($urandom);
    layer_stride_width_i  = 2'($urandom);
    layer_stride_height_i = 2'($urandom);
  endtask

  // Cycle-by-cycle scoreboard. stop_after >= 0 returns after that many
  // handshakes (no completion checks); otherwise runs until layer_done_o.
  task automatic run_scan(input int rdy_pct, input bit ramp, input int stop_after,
                          input bit chk_lat, output int done_cyc);
    int cyc = 0, last_hs = -1, n_done = 0, n_hs = 0, need;
    bit stall_prev = 0, stopped = 0;
    logic [CW-1:0] pc = '0;
    logic [RW-1:0] pr = '0;
    done_cyc = -1;
    while (cyc < 4000) begin
      if (exp_q.size() > 0 && exp_q[0].r == stall_r && exp_q[0].c == stall_c && stall_left > 0)
        ready_i = 1'b0;
      else
        ready_i = ($urandom_range(99) < rdy_pct);
      if (ramp && int'(lb_rows_written_i) < m_h && $urandom_range(3) == 0)
        lb_rows_written_i++;
      @(negedge clk_i);
      if (chk_lat && cyc == 0) chk("lat_cycle1_valid", valid_o, 0);
      if (chk_lat && cyc == 1) chk("lat_cycle2_valid", valid_o, 1);
      if (stall_prev) begin
        chk("hold_valid", valid_o, 1);
        chk("hold_col", read_col_o, pc);
        chk("hold_row", read_row_o, pr);
      end
      if (layer_done_o) begin
        n_done++;
        done_cyc = cyc;
        chk("done_after_last_hs", cyc - last_hs, 1);
        chk("done_pending_windows", exp_q.size(), 0);
      end
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          chk("extra_window", 1, 0);
        end else begin
          need = exp_q[0].r + (K - 1) / 2 + 1;
          if (need > m_h) need = m_h;
          chk("fill_gate", int'(lb_rows_written_i) >= need, 1);
          chk("col", read_col_o, exp_q[0].c);
          chk("row", read_row_o, exp_q[0].r);
          chk("last", last_o, exp_q.size() == 1);
          if (!ready_i && stall_left > 0) stall_left--;
          if (ready_i) begin
            void'(exp_q.pop_front());
            last_hs = cyc;
            n_hs++;
          end
        end
      end
      stall_prev = valid_o && !ready_i;
      pc = read_col_o;
      pr = read_row_o;
      @(posedge clk_i); #1;
      cyc++;
      if (n_done > 0) break;
      if (stop_after >= 0 && n_hs == stop_after) begin
        stopped = 1;
        break;
      end
    end
    if (!stopped) begin
      chk("done_count", n_done, 1);
      chk("queue_drained", exp_q.size(), 0);
    end
  endtask

  task automatic post_idle();
    @(negedge clk_i);
    chk("idle_done", layer_done_o, 0);
    chk("idle_busy", busy_o, 0);
    chk("idle_valid", valid_o, 0);
    @(posedge clk_i); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, valid_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, layer_done_o, 0);
    chk({tag, "_last"}, last_o, 0);
    chk({tag, "_col"}, read_col_o, 0);
    chk({tag, "_row"}, read_row_o, 0);
  endtask

  initial begin
    int dc, need;
    padding_type pad;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk_all_zero("reset");
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // SAME 4x4 stride 1, full linebuffer, always ready
    lb_rows_written_i = 6'd4;
    start_layer(PAD_SAME, 4, 4, 1, 1);
    run_scan(100, 0, -1, 1, dc);
    chk("same4x4_done_cycle", dc, 20);
    post_idle();

    // VALID 5x5 stride 2/2
    lb_rows_written_i = 6'd5;
    start_layer(PAD_VALID, 5, 5, 2, 2);
    run_scan(100, 0, -1, 0, dc);
    post_idle();

    // Backpressure: 3 stalled cycles on window (0,2)
    lb_rows_written_i = 6'd4;
    stall_r = 0; stall_c = 2; stall_left = 3;
    start_layer(PAD_SAME, 4, 4, 1, 1);
    run_scan(100, 0, -1, 0, dc);
    chk("stall_consumed", stall_left, 0);
    stall_r = -1; stall_c = -1; stall_left = 0;
    post_idle();

    // Fill gating, SAME 4x4: each row waits for its bottom kernel row
    lb_rows_written_i = 6'd1;
    start_layer(PAD_SAME, 4, 4, 1, 1);
    for (int r = 0; r < 4; r++) begin
      need = (r + 2 > 4) ? 4 : r + 2;
      if (int'(lb_rows_written_i) < need) begin
        repeat (5) begin
          @(negedge clk_i);
          chk("fill_stall", valid_o, 0);
          @(posedge clk_i); #1;
        end
        lb_rows_written_i = 6'(need);
      end
      run_scan(100, 0, (r == 3) ? -1 : 4, 0, dc);
    end
    post_idle();

    // Abort at (2,1): restart at (0,0), no done for the aborted layer
    lb_rows_written_i = 6'd4;
    start_layer(PAD_SAME, 4, 4, 1, 1);
    run_scan(100, 0, 9, 0, dc);
    build_model(PAD_SAME, 4, 4, 1, 1);
    drive_cfg(PAD_SAME, 4, 4, 1, 1);
    new_layer_i = 1'b1;
    ready_i = 1'b0;
    @(negedge clk_i);
    chk("abort_pos_col", read_col_o, 1);
    chk("abort_pos_row", read_row_o, 2);
    @(posedge clk_i); #1;
    new_layer_i = 1'b0;
    @(negedge clk_i);
    chk("abort_valid_drop", valid_o, 0);
    chk("abort_no_done", layer_done_o, 0);
    @(posedge clk_i); #1;
    run_scan(100, 0, -1, 0, dc);
    post_idle();

    // Async reset mid-scan
    lb_rows_written_i = 6'd5;
    start_layer(PAD_SAME, 6, 5, 1, 1);
    run_scan(100, 0, 5, 0, dc);
    rst_ni = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    post_idle();

    // VALID with image narrower than the kernel: immediate done
    lb_rows_written_i = 6'd0;
    start_layer(PAD_VALID, 2, 8, 1, 1);
    @(negedge clk_i);
    chk("tiny_done", layer_done_o, 1);
    chk("tiny_busy", busy_o, 1);
    chk("tiny_valid", valid_o, 0);
    @(posedge clk_i); #1;
    post_idle();

    // Randomized layers with random backpressure and a slowly filling linebuffer
    for (int i = 0; i < 12; i++) begin
      pad = padding_type'($urandom_range(1));
      lb_rows_written_i = '0;
      start_layer(pad, $urandom_range(1, 10), $urandom_range(1, 10),
                  $urandom_range(3), $urandom_range(3));
      run_scan(60, 1, -1, 0, dc);
      post_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
